// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
// Module   : sha256_compress
// Purpose  : SHA-256 compression engine. Accepts the 64-word message schedule
//            W0..W63 (one word per accepted beat), runs the 64 compression
//            rounds on working variables a..h, then folds the result into
//            the chaining value H0..H7.
// Ports    : clk, rst_n (async, active-low)
//            init_in          - reload H with the IV (IDLE only)
//            start_in         - begin a block (IDLE only)
//            w_valid_in/w_in  - schedule word stream, handshake with w_ready_out
//            w_ready_out      - high while in ROUNDS
//            busy_out         - high whenever not IDLE
//            digest_valid_out - one-cycle pulse in DONE
//            digest_out       - {H0..H7}, H0 in the top word
//            o_round          - round counter t
//            o_FSM_state      - IDLE=00 ROUNDS=01 UPDATE=10 DONE=11
// Revision : 1.0 - initial release
// ============================================================================
module sha256_compress #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_in,
    input  logic                  start_in,
    input  logic                  w_valid_in,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic                  w_ready_out,
    output logic                  busy_out,
    output logic                  digest_valid_out,
    output logic [255:0]          digest_out,
    output logic [5:0]            o_round,
    output logic [1:0]            o_FSM_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ROUNDS = 2'b01,
        S_UPDATE = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    localparam logic [255:0] c_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] c_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t            r_state;
    state_t            w_next_state;
    logic [5:0]        r_t;
    // Index 0 is the most significant word, so the packed vectors line up
    // directly with the {a..h} / {H0..H7} digest ordering.
    logic [0:7][31:0]  r_wv;
    logic [0:7][31:0]  r_hv;

    logic              w_accept;
    logic [31:0]       w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0]       w_sig0, w_sig1, w_ch, w_maj, w_t1, w_t2;

    assign w_a = r_wv[0];
    assign w_b = r_wv[1];
    assign w_c = r_wv[2];
    assign w_d = r_wv[3];
    assign w_e = r_wv[4];
    assign w_f = r_wv[5];
    assign w_g = r_wv[6];
    assign w_h = r_wv[7];

    // Rotations are written as concatenations: ROTRn(x) = {x[n-1:0], x[31:n]}
    assign w_sig0 = {w_a[1:0],  w_a[31:2]}  ^ {w_a[12:0], w_a[31:13]} ^ {w_a[21:0], w_a[31:22]};
    assign w_sig1 = {w_e[5:0],  w_e[31:6]}  ^ {w_e[10:0], w_e[31:11]} ^ {w_e[24:0], w_e[31:25]};
    assign w_ch   = (w_e & w_f) ^ (~w_e & w_g);
    assign w_maj  = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    assign w_t1   = w_h + w_sig1 + w_ch + c_K[r_t] + w_in;
    assign w_t2   = w_sig0 + w_maj;

    assign w_accept = w_valid_in && (r_state == S_ROUNDS);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_ready_out      = 1'b0;
        busy_out         = 1'b1;
        digest_valid_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    w_next_state = S_ROUNDS;
                end
            end
            S_ROUNDS: begin
                w_ready_out = 1'b1;
                if (w_accept && (r_t == 6'd63)) begin
                    w_next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                digest_valid_out = 1'b1;
                w_next_state     = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: working variables, round counter, chaining value
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wv <= '0;
            r_t  <= 6'd0;
            r_hv <= c_IV;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init_in) begin
                        r_hv <= c_IV;
                    end
                    if (start_in) begin
                        // init_in on the same cycle means the block starts
                        // from the IV, not from the stale chaining value.
                        r_wv <= init_in ? c_IV : r_hv;
                        r_t  <= 6'd0;
                    end
                end
                S_ROUNDS: begin
                    if (w_accept) begin
                        r_wv <= {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
                        // 63 + 1 wraps to 0, so o_round reads 0 in UPDATE/DONE.
                        r_t  <= r_t + 6'd1;
                    end
                end
                S_UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        r_hv[i] <= r_hv[i] + r_wv[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign digest_out  = r_hv;
    assign o_round     = r_t;
    assign o_FSM_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_compress
// Purpose  : Self-checking bench for sha256_compress. A transaction-level
//            model (message expansion + full compression function) predicts
//            every output each cycle; known SHA-256 digests pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_compress;

    typedef logic [31:0] sched_t [64];
    typedef logic [31:0] blk_t [16];

    localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         init_in    = 1'b0;
    logic         start_in   = 1'b0;
    logic         w_valid_in = 1'b0;
    logic [31:0]  w_in       = 32'h0;
    logic         w_ready_out;
    logic         busy_out;
    logic         digest_valid_out;
    logic [255:0] digest_out;
    logic [5:0]   o_round;
    logic [1:0]   o_FSM_state;

    always #5 clk = ~clk;

    sha256_compress #(.DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init_in          (init_in),
        .start_in         (start_in),
        .w_valid_in       (w_valid_in),
        .w_in             (w_in),
        .w_ready_out      (w_ready_out),
        .busy_out         (busy_out),
        .digest_valid_out (digest_valid_out),
        .digest_out       (digest_out),
        .o_round          (o_round),
        .o_FSM_state      (o_FSM_state)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int dv_pulses = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference algorithm ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void expand(input blk_t b, output sched_t w);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = b[t];
            else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input sched_t w);
        logic [31:0]  v  [8];
        logic [31:0]  hh [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            hh[i] = hin[255 - 32*i -: 32];
            v[i]  = hh[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hh[i] + v[i];
        return r;
    endfunction

    // ---------------- transaction-level model ----------------
    // m_phase uses the externally visible state numbering of o_FSM_state.
    logic [1:0]   m_phase = 2'd0;
    logic [5:0]   m_t     = 6'd0;
    logic [255:0] m_H     = IV;
    sched_t       m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 2'd0;
            m_t     = 6'd0;
            m_H     = IV;
        end else begin
            case (m_phase)
                2'd0: begin
                    if (init_in) m_H = IV;
                    if (start_in) begin
                        m_t     = 6'd0;
                        m_phase = 2'd1;
                    end
                end
                2'd1: if (w_valid_in) begin
                    m_w[m_t] = w_in;
                    if (m_t == 6'd63) m_phase = 2'd2;
                    m_t = m_t + 6'd1;
                end
                2'd2: begin
                    m_H     = compress(m_H, m_w);
                    m_phase = 2'd3;
                end
                default: m_phase = 2'd0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("state",   256'(o_FSM_state),      256'(m_phase));
        chk("round",   256'(o_round),          256'(m_t));
        chk("busy",    256'(busy_out),         256'(m_phase != 2'd0));
        chk("ready",   256'(w_ready_out),      256'(m_phase == 2'd1));
        chk("dvalid",  256'(digest_valid_out), 256'(m_phase == 2'd3));
        chk("digest",  digest_out,             m_H);
        if (digest_valid_out) dv_pulses++;
    end

    // ---------------- stimulus ----------------
    blk_t cur_blk;

    task automatic set_block(input int id);
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
        case (id)
            0: begin cur_blk[0] = 32'h61626380; cur_blk[15] = 32'h00000018; end
            1: begin cur_blk[0] = 32'h80000000; end
            2: begin
                cur_blk[0]  = 32'h61626364; cur_blk[1]  = 32'h62636465;
                cur_blk[2]  = 32'h63646566; cur_blk[3]  = 32'h64656667;
                cur_blk[4]  = 32'h65666768; cur_blk[5]  = 32'h66676869;
                cur_blk[6]  = 32'h6768696a; cur_blk[7]  = 32'h68696a6b;
                cur_blk[8]  = 32'h696a6b6c; cur_blk[9]  = 32'h6a6b6c6d;
                cur_blk[10] = 32'h6b6c6d6e; cur_blk[11] = 32'h6c6d6e6f;
                cur_blk[12] = 32'h6d6e6f70; cur_blk[13] = 32'h6e6f7071;
                cur_blk[14] = 32'h80000000;
            end
            default: begin cur_blk[15] = 32'h000001c0; end
        endcase
    endtask

    // Called at #1 after a rising edge with the DUT idle.
    task automatic run_block(input bit do_init, input int stall_pct, input bit poke,
                             input bit has_exp, input logic [255:0] exp_dig, input string nm);
        sched_t w;
        int     cyc, beat, stalls;
        bit     got;
        expand(cur_blk, w);
        start_in = 1'b1; init_in = do_init; w_valid_in = 1'b0;
        @(posedge clk); #1;
        start_in = 1'b0; init_in = 1'b0;
        cyc = 1; beat = 0; stalls = 0; got = 1'b0;
        while (!got && cyc < 300) begin
            if (beat < 64) begin
                if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                    w_valid_in = 1'b0; w_in = $urandom; stalls++;
                end else begin
                    w_valid_in = 1'b1; w_in = w[beat];
                end
            end else begin
                w_valid_in = poke; w_in = $urandom;
            end
            if (poke) begin
                start_in = 1'($urandom_range(1));
                init_in  = 1'($urandom_range(1));
            end
            @(negedge clk);
            if (digest_valid_out) begin
                got = 1'b1;
                chk({nm, " latency"}, 256'(cyc), 256'(66 + stalls));
                if (has_exp) chk({nm, " digest"}, digest_out, exp_dig);
            end
            if (w_valid_in && w_ready_out && beat < 64) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        start_in = 1'b0; init_in = 1'b0; w_valid_in = 1'b0;
        chk({nm, " done pulse seen"}, 256'(got), 256'(1));
    endtask

    initial begin
        sched_t w;
        int     pulses0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset digest", digest_out, IV);
        chk("reset busy",   256'(busy_out), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle state",   256'(o_FSM_state), 256'(0));

        // "abc", no stalls
        set_block(0);
        run_block(1'b1, 0, 1'b0, 1'b1, ABC, "abc");
        chk("abc held", digest_out, ABC);

        // empty message
        set_block(1);
        run_block(1'b1, 0, 1'b0, 1'b1, EMPTY, "empty");

        // two-block message, init on the first block only
        set_block(2);
        run_block(1'b1, 0, 1'b0, 1'b0, '0, "two blk1");
        set_block(3);
        run_block(1'b0, 0, 1'b0, 1'b1, TWO, "two blk2");

        // "abc" with ~30% stalls
        set_block(0);
        run_block(1'b1, 30, 1'b0, 1'b1, ABC, "abc stall");

        // "abc" with control inputs poked outside IDLE
        set_block(0);
        run_block(1'b1, 0, 1'b1, 1'b1, ABC, "abc poke");
        w_valid_in = 1'b1;
        repeat (4) begin w_in = $urandom; @(posedge clk); #1; end
        w_valid_in = 1'b0;
        chk("idle w_valid ignored", digest_out, ABC);
        chk("idle state kept", 256'(o_FSM_state), 256'(0));

        // abort at t=30 via async reset
        set_block(0);
        expand(cur_blk, w);
        start_in = 1'b1; init_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0; init_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            w_valid_in = 1'b1; w_in = w[i];
            @(posedge clk); #1;
        end
        w_valid_in = 1'b0;
        chk("abort round", 256'(o_round), 256'(30));
        pulses0 = dv_pulses;
        rst_n = 1'b0;
        #1;
        chk("abort digest IV", digest_out, IV);
        chk("abort state", 256'(o_FSM_state), 256'(0));
        chk("abort round clr", 256'(o_round), 256'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no pulse", 256'(dv_pulses), 256'(pulses0));
        run_block(1'b1, 0, 1'b0, 1'b1, ABC, "abc rerun");

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
